// File: rtl/control_fsm_pkg.sv
// Shared encodings for the multicycle RV32I main controller: states, opcodes,
// datapath select codes and the packed Moore control word.
package control_fsm_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned ALUOP_W  = 3;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_e;

    localparam logic [OPCODE_W-1:0] OP_LW    = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_RTYPE = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_ITYPE = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_BTYPE = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_JTYPE = 7'b1101111;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b000;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'b001;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 3'b010;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

    typedef struct packed {
        logic               adr_src;
        logic               ir_write;
        logic               pc_update;
        logic               mem_write;
        logic               reg_write;
        logic               branch;
        logic [SEL_W-1:0]   alu_src_a;
        logic [SEL_W-1:0]   alu_src_b;
        logic [SEL_W-1:0]   result_src;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/control_out_decode.sv
// Moore output table: maps the current controller state to the datapath control word.
module control_out_decode
    import control_fsm_pkg::*;
(
    input  logic [STATE_W-1:0] state_i,
    output ctrl_t              ctrl_o
);

    always_comb begin
        ctrl_o            = '0;
        ctrl_o.alu_src_a  = SRCA_PC;
        ctrl_o.alu_src_b  = SRCB_RS2;
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.alu_op     = ALUOP_ADD;
        case (state_i)
            S_FETCH: begin
                ctrl_o.adr_src    = 1'b0;
                ctrl_o.ir_write   = 1'b1;
                ctrl_o.alu_src_a  = SRCA_PC;
                ctrl_o.alu_src_b  = SRCB_FOUR;
                ctrl_o.result_src = RES_ALURESULT;
                ctrl_o.pc_update  = 1'b1;
            end
            S_DECODE: begin
                // Branch target is precomputed here so BEQ only has to compare.
                ctrl_o.alu_src_a = SRCA_OLDPC;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                ctrl_o.alu_src_a = SRCA_RS1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.adr_src    = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.result_src = RES_DATA;
                ctrl_o.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.adr_src    = 1'b1;
                ctrl_o.mem_write  = 1'b1;
            end
            S_EXECUTER: begin
                ctrl_o.alu_src_a = SRCA_RS1;
                ctrl_o.alu_src_b = SRCB_RS2;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ctrl_o.alu_src_a = SRCA_RS1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.reg_write  = 1'b1;
            end
            S_BEQ: begin
                ctrl_o.alu_src_a  = SRCA_RS1;
                ctrl_o.alu_src_b  = SRCB_RS2;
                ctrl_o.alu_op     = ALUOP_SUB;
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.branch     = 1'b1;
            end
            S_JAL: begin
                ctrl_o.alu_src_a  = SRCA_OLDPC;
                ctrl_o.alu_src_b  = SRCB_FOUR;
                ctrl_o.result_src = RES_ALUOUT;
                ctrl_o.pc_update  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multicycle RV32I main controller: state register, next-state logic, and
// reset gating of the write enables driven from the Moore output table.
module control_fsm
    import control_fsm_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    output logic                AdrSrc,
    output logic                IRWrite,
    output logic                PCUpdate,
    output logic                PCWrite,
    output logic                MemWrite,
    output logic                RegWrite,
    output logic                Branch,
    output logic [SEL_W-1:0]    ALUSrcA,
    output logic [SEL_W-1:0]    ALUSrcB,
    output logic [SEL_W-1:0]    ResultSrc,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic [STATE_W-1:0]  state,
    output logic                illegal
);

    state_e state_q;
    state_e state_d;
    logic   bad_op;
    ctrl_t  ctrl;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Opcode only influences the transitions out of DECODE and MEMADR.
    always_comb begin
        state_d = S_FETCH;
        bad_op  = 1'b0;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTER;
                    OP_ITYPE:     state_d = S_EXECUTEI;
                    OP_BTYPE:     state_d = S_BEQ;
                    OP_JTYPE:     state_d = S_JAL;
                    default: begin
                        state_d = S_FETCH;
                        bad_op  = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_LW) begin
                    state_d = S_MEMREAD;
                end else if (opcode == OP_SW) begin
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMREAD:                    state_d = S_MEMWB;
            S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
            default:                      state_d = S_FETCH;
        endcase
    end

    control_out_decode u_out_decode (
        .state_i (state_q),
        .ctrl_o  (ctrl)
    );

    // While reset is low the state already reads FETCH; the enables are masked
    // so nothing gets written in the same cycle the reset lands.
    assign AdrSrc    = ctrl.adr_src;
    assign IRWrite   = ctrl.ir_write  & reset;
    assign PCUpdate  = ctrl.pc_update & reset;
    assign PCWrite   = (ctrl.pc_update | (ctrl.branch & zero)) & reset;
    assign MemWrite  = ctrl.mem_write & reset;
    assign RegWrite  = ctrl.reg_write & reset;
    assign Branch    = ctrl.branch;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign ResultSrc = ctrl.result_src;
    assign ALUOp     = ctrl.alu_op;
    assign state     = state_q;
    assign illegal   = bad_op & reset;

endmodule
